// File: rtl/ethernet_package.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_package
// Description : Shared Ethernet receive definitions: deframer state encoding,
//               preamble/SFD byte values and the CRC-32 constants and
//               byte-update function.
// Revision    : 1.0 - initial release
// ============================================================================
package ethernet_package;

    // Receive deframer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  c_preamble_byte = 8'h55;
    localparam logic [7:0]  c_sfd_byte      = 8'hD5;

    // CRC-32 in MSB-first register form with LSB-first data input. Running it
    // over data plus a correct FCS always leaves the fixed residue below.
    localparam logic [31:0] c_crc_poly      = 32'h04C11DB7;
    localparam logic [31:0] c_crc_init      = 32'hFFFFFFFF;
    localparam logic [31:0] c_crc_residue   = 32'hC704DD7B;

    // Bytes held back so the 4 FCS bytes never reach the output.
    localparam int          c_stage_depth   = 5;

    // One byte of CRC-32; data bits enter least-significant first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [31:0] v_crc;
        logic        v_feedback;
        v_crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            v_feedback = v_crc[31] ^ data_in[i];
            v_crc      = {v_crc[30:0], 1'b0};
            if (v_feedback) begin
                v_crc = v_crc ^ c_crc_poly;
            end
        end
        return v_crc;
    endfunction

endpackage : ethernet_package
`default_nettype wire

// File: rtl/ethernet_crc32.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_crc32
// Description : Byte-wise Ethernet CRC-32 accumulator with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ethernet_crc32
    import ethernet_package::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        data_valid,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] r_crc;

    // Accumulate one byte per strobe; clear returns the register to init.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= c_crc_init;
        end else if (clear) begin
            r_crc <= c_crc_init;
        end else if (data_valid) begin
            r_crc <= crc32_next(r_crc, data);
        end
    end

    assign crc = r_crc;

endmodule : ethernet_crc32
`default_nettype wire

// File: rtl/gmii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : gmii_rx_deframer
// Description : Strips preamble, SFD and FCS from received GMII frames,
//               checks CRC/length/PHY error and flags bad or dropped frames.
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_rx_deframer
    import ethernet_package::*;
#(
    parameter int MAXIMUM_FRAME_BYTES = 1518,
    parameter int MINIMUM_FRAME_BYTES = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       gmii_rx_data_valid,
    input  logic [7:0] gmii_rx_data,
    input  logic       gmii_rx_error,
    output logic [7:0] frame_data,
    output logic       frame_data_valid,
    output logic       frame_data_last,
    output logic       frame_error,
    output logic       frame_dropped
);

    localparam int                     c_len_width = $clog2(MAXIMUM_FRAME_BYTES + 2);
    localparam logic [c_len_width-1:0] c_len_sat   = c_len_width'(MAXIMUM_FRAME_BYTES + 1);
    localparam logic [c_len_width-1:0] c_len_max   = c_len_width'(MAXIMUM_FRAME_BYTES);
    localparam logic [c_len_width-1:0] c_len_min   = c_len_width'(MINIMUM_FRAME_BYTES);
    localparam logic [c_len_width-1:0] c_len_stage = c_len_width'(c_stage_depth);

    rx_state_t              r_state;
    rx_state_t              w_next_state;
    logic [7:0]             r_stage [c_stage_depth];
    logic [c_len_width-1:0] r_len;
    logic                   r_rx_err;
    logic                   r_seen_idle;
    logic [31:0]            w_crc;
    logic                   w_in_payload;
    logic                   w_payload_byte;
    logic                   w_staged_full;
    logic                   w_frame_bad;
    logic                   w_emit;
    logic                   w_emit_last;
    logic                   w_drop_pulse;

    assign w_in_payload   = (r_state == PAYLOAD);
    assign w_payload_byte = w_in_payload && gmii_rx_data_valid;
    assign w_staged_full  = (r_len >= c_len_stage);
    assign w_frame_bad    = (w_crc != c_crc_residue) || r_rx_err ||
                            (r_len < c_len_min) || (r_len > c_len_max);

    ethernet_crc32 u_crc (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (!w_in_payload),
        .data_valid (w_payload_byte),
        .data       (gmii_rx_data),
        .crc        (w_crc)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus emit/drop decisions for the coming cycle. IDLE ignores
    // bytes until the line has gone quiet once after reset, so the tail of a
    // frame cut by reset is discarded without a drop pulse.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_emit_last  = 1'b0;
        w_drop_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                if (gmii_rx_data_valid && r_seen_idle) begin
                    if (enable && gmii_rx_data == c_preamble_byte) begin
                        w_next_state = PREAMBLE;
                    end else if (enable && gmii_rx_data == c_sfd_byte) begin
                        w_next_state = PAYLOAD;
                    end else begin
                        w_next_state = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_data_valid) begin
                    w_next_state = IDLE;
                end else if (gmii_rx_data == c_sfd_byte) begin
                    w_next_state = PAYLOAD;
                end else if (gmii_rx_data != c_preamble_byte) begin
                    w_next_state = DROP;
                end
            end
            PAYLOAD: begin
                if (!gmii_rx_data_valid) begin
                    w_next_state = IDLE;
                    if (w_staged_full) begin
                        w_emit      = 1'b1;
                        w_emit_last = 1'b1;
                    end else begin
                        w_drop_pulse = 1'b1;
                    end
                end else if (w_staged_full) begin
                    w_emit = 1'b1;
                end
            end
            DROP: begin
                if (!gmii_rx_data_valid) begin
                    w_next_state = IDLE;
                    w_drop_pulse = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Staging shift register, saturating length, sticky PHY error and the
    // registered output stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_stage_depth; i++) begin
                r_stage[i] <= 8'h00;
            end
            r_len            <= '0;
            r_rx_err         <= 1'b0;
            r_seen_idle      <= 1'b0;
            frame_data       <= 8'h00;
            frame_data_valid <= 1'b0;
            frame_data_last  <= 1'b0;
            frame_error      <= 1'b0;
            frame_dropped    <= 1'b0;
        end else begin
            r_seen_idle      <= r_seen_idle || !gmii_rx_data_valid;
            frame_data       <= w_emit ? r_stage[c_stage_depth-1] : 8'h00;
            frame_data_valid <= w_emit;
            frame_data_last  <= w_emit_last;
            frame_error      <= w_emit_last && w_frame_bad;
            frame_dropped    <= w_drop_pulse;
            if (w_payload_byte) begin
                r_stage[0] <= gmii_rx_data;
                for (int i = 1; i < c_stage_depth; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
                if (r_len != c_len_sat) begin
                    r_len <= r_len + 1'b1;
                end
                if (gmii_rx_error) begin
                    r_rx_err <= 1'b1;
                end
            end else if (!w_in_payload) begin
                r_len    <= '0;
                r_rx_err <= 1'b0;
            end
        end
    end

endmodule : gmii_rx_deframer
`default_nettype wire
